// File: rtl/interfaz_memoria_pkg.sv
// Definitions shared by interfaz_memoria and the ciscud control unit.
// Contents: sequencer state codes, default bus widths, and Fun/Control encodings.
package interfaz_memoria_pkg;

    localparam logic [1:0] REPOSO   = 2'd0;
    localparam logic [1:0] PREPARA  = 2'd1;
    localparam logic [1:0] ACCESO   = 2'd2;
    localparam logic [1:0] RECUPERA = 2'd3;

    localparam int unsigned ANCHO_DIR_DEF = 16;
    localparam int unsigned ANCHO_DAT_DEF = 16;

    typedef enum logic [2:0] {
        FUN_NOP,
        FUN_LEER_MEM,
        FUN_ESCRIBIR_MEM,
        FUN_ALU,
        FUN_SALTO
    } fun_t;

    typedef struct packed {
        logic cargaAR;
        logic cargaDR;
        logic cargaIR;
        logic pedido;
        logic escribe;
    } control_t;

    function automatic logic esAccesoMemoria(input fun_t f);
        return (f == FUN_LEER_MEM) || (f == FUN_ESCRIBIR_MEM);
    endfunction

endpackage

// File: rtl/interfaz_memoria_contador_esperas.sv
// contador_esperas: loadable up-counter that saturates at LIMITE-1.
// Terminal is high once the count has reached LIMITE-1.
module contador_esperas #(
    parameter int unsigned LIMITE = 2
) (
    input  logic Reloj,
    input  logic Reiniciar,
    input  logic Carga,
    input  logic Habilita,
    output logic Terminal
);

    localparam int unsigned ANCHO = (LIMITE < 2) ? 1 : $clog2(LIMITE);
    localparam logic [ANCHO-1:0] FIN = ANCHO'(LIMITE - 1);

    logic [ANCHO-1:0] cuenta;

    assign Terminal = (cuenta >= FIN);

    always_ff @(posedge Reloj or negedge Reiniciar) begin
        if (!Reiniciar) begin
            cuenta <= '0;
        end else if (Carga) begin
            cuenta <= '0;
        end else if (Habilita && !Terminal) begin
            cuenta <= cuenta + 1'b1;
        end
    end

endmodule

// File: rtl/interfaz_memoria.sv
// Memory-bus sequencer between the ciscud control unit and an asynchronous SRAM.
// Optional watchdog abort: define INTERFAZ_MEMORIA_TIMEOUT_EN.
module interfaz_memoria
    import interfaz_memoria_pkg::*;
#(
    parameter int unsigned ANCHO_DIR = ANCHO_DIR_DEF,
    parameter int unsigned ANCHO_DAT = ANCHO_DAT_DEF,
    parameter int unsigned ESPERAS   = 2,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                 Reloj,
    input  logic                 Reiniciar,
    input  logic                 Pedido,
    input  logic                 Escribe,
    input  logic [ANCHO_DIR-1:0] Direccion,
    input  logic [ANCHO_DAT-1:0] DatoEscritura,
    output logic [ANCHO_DAT-1:0] DatoLeido,
    output logic                 Listo,
    output logic                 Ocupado,
    output logic                 Error,
    output logic [ANCHO_DIR-1:0] MemDir,
    output logic [ANCHO_DAT-1:0] MemDatoSal,
    output logic                 MemDatoOE,
    input  logic [ANCHO_DAT-1:0] MemDatoEnt,
    output logic                 MemCS_n,
    output logic                 MemWE_n,
    output logic                 MemOE_n,
    input  logic                 MemListo
);

    if (ESPERAS < 1 || TIMEOUT < ESPERAS) begin : gParametrosInvalidos
        $error("interfaz_memoria: requires ESPERAS >= 1 and TIMEOUT >= ESPERAS");
    end

    logic [1:0] estado;
    logic       esEscritura;
    logic       esperaCumplida;
    logic       fin;
    logic       aborta;

    contador_esperas #(.LIMITE(ESPERAS)) uEsperas (
        .Reloj     (Reloj),
        .Reiniciar (Reiniciar),
        .Carga     (estado == PREPARA),
        .Habilita  (estado == ACCESO),
        .Terminal  (esperaCumplida)
    );

    assign fin = esperaCumplida && MemListo;

`ifdef INTERFAZ_MEMORIA_TIMEOUT_EN
    logic vigilanciaCumplida;
    logic errorReg;

    contador_esperas #(.LIMITE(TIMEOUT)) uVigilancia (
        .Reloj     (Reloj),
        .Reiniciar (Reiniciar),
        .Carga     (estado == PREPARA),
        .Habilita  (estado == ACCESO),
        .Terminal  (vigilanciaCumplida)
    );

    assign aborta = vigilanciaCumplida && !fin;
    assign Error  = errorReg;

    always_ff @(posedge Reloj or negedge Reiniciar) begin
        if (!Reiniciar) begin
            errorReg <= 1'b0;
        end else if (estado == REPOSO && Pedido) begin
            errorReg <= 1'b0;
        end else if (estado == ACCESO && aborta) begin
            errorReg <= 1'b1;
        end
    end
`else
    assign aborta = 1'b0;
    assign Error  = 1'b0;
`endif

    // Strobes are registered one state ahead so they line up with the state they describe.
    always_ff @(posedge Reloj or negedge Reiniciar) begin
        if (!Reiniciar) begin
            estado      <= REPOSO;
            esEscritura <= 1'b0;
            DatoLeido   <= '0;
            Listo       <= 1'b0;
            Ocupado     <= 1'b0;
            MemDir      <= '0;
            MemDatoSal  <= '0;
            MemDatoOE   <= 1'b0;
            MemCS_n     <= 1'b1;
            MemWE_n     <= 1'b1;
            MemOE_n     <= 1'b1;
        end else begin
            case (estado)
                REPOSO: begin
                    if (Pedido) begin
                        estado      <= PREPARA;
                        esEscritura <= Escribe;
                        MemDir      <= Direccion;
                        MemDatoSal  <= DatoEscritura;
                        MemDatoOE   <= Escribe;
                        MemCS_n     <= 1'b0;
                        Ocupado     <= 1'b1;
                    end
                end
                PREPARA: begin
                    estado  <= ACCESO;
                    MemOE_n <= esEscritura;
                    MemWE_n <= !esEscritura;
                end
                ACCESO: begin
                    if (fin || aborta) begin
                        estado    <= RECUPERA;
                        MemOE_n   <= 1'b1;
                        MemWE_n   <= 1'b1;
                        MemCS_n   <= 1'b1;
                        MemDatoOE <= 1'b0;
                        Listo     <= 1'b1;
                        if (fin && !esEscritura) begin
                            DatoLeido <= MemDatoEnt;
                        end
                    end
                end
                default: begin
                    estado  <= REPOSO;
                    Listo   <= 1'b0;
                    Ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interfaz_memoria.sv
// Directed testbench for interfaz_memoria with a read-data/error scoreboard.
// Covers the watchdog path when INTERFAZ_MEMORIA_TIMEOUT_EN is defined.
module tb_interfaz_memoria;

    logic        Reloj = 1'b0;
    logic        Reiniciar;
    logic        Pedido;
    logic        Escribe;
    logic [15:0] Direccion;
    logic [15:0] DatoEscritura;
    logic [15:0] DatoLeido;
    logic        Listo;
    logic        Ocupado;
    logic        Error;
    logic [15:0] MemDir;
    logic [15:0] MemDatoSal;
    logic        MemDatoOE;
    logic [15:0] MemDatoEnt;
    logic        MemCS_n;
    logic        MemWE_n;
    logic        MemOE_n;
    logic        MemListo;

    interfaz_memoria #(
        .ANCHO_DIR (16),
        .ANCHO_DAT (16),
        .ESPERAS   (2),
        .TIMEOUT   (15)
    ) dut (
        .Reloj         (Reloj),
        .Reiniciar     (Reiniciar),
        .Pedido        (Pedido),
        .Escribe       (Escribe),
        .Direccion     (Direccion),
        .DatoEscritura (DatoEscritura),
        .DatoLeido     (DatoLeido),
        .Listo         (Listo),
        .Ocupado       (Ocupado),
        .Error         (Error),
        .MemDir        (MemDir),
        .MemDatoSal    (MemDatoSal),
        .MemDatoOE     (MemDatoOE),
        .MemDatoEnt    (MemDatoEnt),
        .MemCS_n       (MemCS_n),
        .MemWE_n       (MemWE_n),
        .MemOE_n       (MemOE_n),
        .MemListo      (MemListo)
    );

    always #5 Reloj = ~Reloj;

    typedef struct {
        logic [15:0] dato;
        logic        err;
    } esperado_t;

    esperado_t sb[$];
    int errores = 0;
    int checks  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errores++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle request; returns at edge k + 1ns (cycle k+1).
    task automatic pedir(input logic esc, input logic [15:0] dir, input logic [15:0] dat);
        Pedido        = 1'b1;
        Escribe       = esc;
        Direccion     = dir;
        DatoEscritura = dat;
        @(posedge Reloj); #1;
        Pedido = 1'b0;
    endtask

    // Steps cycle by cycle until Listo; n is the cycle index relative to k.
    task automatic correr(input bit repulsa, input bit stall,
                          output int n, output int nOE, output int nWE,
                          output int nDOE, output bit solape);
        bit visto = 0;
        esperado_t e;
        n = 1; nOE = 0; nWE = 0; nDOE = 0; solape = 0;
        while (!visto && n <= 200) begin
            if (repulsa) begin
                Pedido    = (n == 2 || n == 4);
                Direccion = 16'h1111;
            end
            if (stall) begin
                MemListo   = !(n >= 3 && n <= 5);
                MemDatoEnt = 16'hA000 + 16'(n);
            end
            if (!MemOE_n) nOE++;
            if (!MemWE_n) nWE++;
            if (MemDatoOE) nDOE++;
            if (MemDatoOE && !MemOE_n) solape = 1;
            if (Listo) begin
                visto = 1;
                if (sb.size() == 0) begin
                    chk("scoreboard_vacio", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("dato_leido", 32'(DatoLeido), 32'(e.dato));
                    chk("error_flag", 32'(Error), 32'(e.err));
                end
            end else begin
                @(posedge Reloj); #1;
                n++;
            end
        end
        if (!visto) chk("listo_timeout", 32'd0, 32'd1);
        Pedido = 1'b0;
        if (stall) MemListo = 1'b1;
    endtask

    int n, nOE, nWE, nDOE;
    bit solape;
    bit listoVisto;
    bit siempreOcupado;
    logic [15:0] ultimo;

    initial begin
        Reiniciar     = 1'b0;
        Pedido        = 1'b0;
        Escribe       = 1'b0;
        Direccion     = '0;
        DatoEscritura = '0;
        MemDatoEnt    = '0;
        MemListo      = 1'b1;

        #22;
        chk("rst_strobes", 32'({MemCS_n, MemWE_n, MemOE_n}), 32'b111);
        chk("rst_flags", 32'({Listo, Ocupado, Error, MemDatoOE}), 32'b0000);
        chk("rst_datoleido", 32'(DatoLeido), 32'h0);
        chk("rst_memdir", 32'(MemDir), 32'h0);
        chk("rst_memdatosal", 32'(MemDatoSal), 32'h0);
        Reiniciar = 1'b1;
        @(posedge Reloj); #1;

        // Basic read.
        MemDatoEnt = 16'hBEEF;
        sb.push_back('{16'hBEEF, 1'b0});
        pedir(1'b0, 16'h0040, 16'h0000);
        chk("rd_memdir", 32'(MemDir), 32'h0040);
        chk("rd_prepara", 32'({MemCS_n, MemDatoOE, Ocupado}), 32'b001);
        correr(0, 0, n, nOE, nWE, nDOE, solape);
        chk("rd_latencia", 32'(n), 32'd4);
        chk("rd_oe_ciclos", 32'(nOE), 32'd2);
        chk("rd_we_ciclos", 32'(nWE), 32'd0);
        chk("rd_recupera_cs", 32'(MemCS_n), 32'd1);
        chk("rd_recupera_dir", 32'(MemDir), 32'h0040);
        @(posedge Reloj); #1;
        chk("rd_listo_pulso", 32'({Listo, Ocupado}), 32'b00);
        ultimo = 16'hBEEF;

        // Write.
        MemDatoEnt = 16'h5555;
        sb.push_back('{ultimo, 1'b0});
        pedir(1'b1, 16'h00FF, 16'h1234);
        chk("wr_memdir", 32'(MemDir), 32'h00FF);
        chk("wr_memdatosal", 32'(MemDatoSal), 32'h1234);
        correr(0, 0, n, nOE, nWE, nDOE, solape);
        chk("wr_latencia", 32'(n), 32'd4);
        chk("wr_we_ciclos", 32'(nWE), 32'd2);
        chk("wr_oe_ciclos", 32'(nOE), 32'd0);
        chk("wr_doe_ciclos", 32'(nDOE), 32'd3);
        chk("wr_solape", 32'(solape), 32'd0);
        chk("wr_doe_recupera", 32'(MemDatoOE), 32'd0);
        @(posedge Reloj); #1;

        // Read with MemListo low for three cycles.
        sb.push_back('{16'hA006, 1'b0});
        pedir(1'b0, 16'h0100, 16'h0000);
        correr(0, 1, n, nOE, nWE, nDOE, solape);
        chk("stall_latencia", 32'(n), 32'd7);
        chk("stall_oe_ciclos", 32'(nOE), 32'd5);
        ultimo = 16'hA006;
        @(posedge Reloj); #1;

        // Pedido re-pulsed in ACCESO and in the Listo cycle is ignored.
        MemDatoEnt = 16'h5A5A;
        sb.push_back('{16'h5A5A, 1'b0});
        pedir(1'b0, 16'h0333, 16'h0000);
        correr(1, 0, n, nOE, nWE, nDOE, solape);
        chk("rep_latencia", 32'(n), 32'd4);
        @(posedge Reloj); #1;
        chk("rep_ignorado", 32'({Ocupado, MemCS_n}), 32'b01);
        chk("rep_memdir", 32'(MemDir), 32'h0333);
        MemDatoEnt = 16'h7777;
        sb.push_back('{16'h7777, 1'b0});
        pedir(1'b0, 16'h0222, 16'h0000);
        chk("rep2_memdir", 32'(MemDir), 32'h0222);
        correr(0, 0, n, nOE, nWE, nDOE, solape);
        chk("rep2_latencia", 32'(n), 32'd4);
        @(posedge Reloj); #1;

        // Asynchronous reset during ACCESO.
        pedir(1'b0, 16'h0444, 16'h0000);
        @(posedge Reloj); #1;
        chk("rst_en_acceso", 32'(MemOE_n), 32'd0);
        #2 Reiniciar = 1'b0;
        #1;
        chk("rst_async_strobes", 32'({MemCS_n, MemWE_n, MemOE_n}), 32'b111);
        chk("rst_async_ocupado", 32'(Ocupado), 32'd0);
        listoVisto = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Reloj); #1;
            listoVisto = listoVisto | Listo;
        end
        chk("rst_sin_listo", 32'(listoVisto), 32'd0);
        #3 Reiniciar = 1'b1;
        @(posedge Reloj); #1;
        MemDatoEnt = 16'h1357;
        sb.push_back('{16'h1357, 1'b0});
        pedir(1'b0, 16'h0555, 16'h0000);
        chk("post_rst_memdir", 32'(MemDir), 32'h0555);
        correr(0, 0, n, nOE, nWE, nDOE, solape);
        chk("post_rst_latencia", 32'(n), 32'd4);
        ultimo = 16'h1357;
        @(posedge Reloj); #1;

        // MemListo stuck low.
        MemListo   = 1'b0;
        MemDatoEnt = 16'hDEAD;
`ifdef INTERFAZ_MEMORIA_TIMEOUT_EN
        sb.push_back('{ultimo, 1'b1});
        pedir(1'b0, 16'h0666, 16'h0000);
        correr(0, 0, n, nOE, nWE, nDOE, solape);
        chk("to_latencia", 32'(n), 32'd17);
        chk("to_oe_ciclos", 32'(nOE), 32'd15);
        @(posedge Reloj); #1;
        chk("to_error_retenido", 32'(Error), 32'd1);
        MemListo   = 1'b1;
        MemDatoEnt = 16'h2468;
        sb.push_back('{16'h2468, 1'b0});
        pedir(1'b0, 16'h0777, 16'h0000);
        chk("to_error_borrado", 32'(Error), 32'd0);
        correr(0, 0, n, nOE, nWE, nDOE, solape);
        chk("to_siguiente_latencia", 32'(n), 32'd4);
`else
        sb.push_back('{16'h2468, 1'b0});
        pedir(1'b0, 16'h0666, 16'h0000);
        siempreOcupado = 1;
        listoVisto = 0;
        for (int i = 0; i < 100; i++) begin
            siempreOcupado = siempreOcupado & Ocupado;
            listoVisto = listoVisto | Listo;
            @(posedge Reloj); #1;
        end
        chk("sin_to_ocupado", 32'(siempreOcupado), 32'd1);
        chk("sin_to_listo", 32'(listoVisto), 32'd0);
        chk("sin_to_error", 32'(Error), 32'd0);
        MemDatoEnt = 16'h2468;
        MemListo   = 1'b1;
        correr(0, 0, n, nOE, nWE, nDOE, solape);
`endif
        @(posedge Reloj); #1;
        chk("scoreboard_vaciado", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end

endmodule
